// File: rtl/servo_pwm_bank.sv
// Multi-channel RC-servo PWM bank driven from the 8051 P1 (address/strobe) and P2 (data) ports.
// Positions are double-buffered: writes land in a shadow copy that goes live at each frame wrap.
module servo_pwm_bank #(
   parameter int unsigned NUM_CH    = 5,
   parameter int unsigned TICK_DIV  = 50,
   parameter int unsigned FRAME_US  = 20000,
   parameter int unsigned MIN_US    = 500,
   parameter int unsigned STEP_US   = 8,
   parameter int unsigned RESET_POS = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        port_addr_i,
   input  logic [7:0]        port_data_i,
   output logic [NUM_CH-1:0] pwm_o,
   output logic              frame_start_o,
   output logic              wr_ack_o
);

   localparam int unsigned    PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [14:0]    FRAME_LAST = 15'(FRAME_US - 1);
   localparam logic [14:0]    MIN_W      = 15'(MIN_US);
   localparam logic [14:0]    STEP_W     = 15'(STEP_US);
   localparam logic [7:0]     RST_POS    = 8'(RESET_POS);
   localparam logic [3:0]     NCH4       = 4'(NUM_CH);

   logic [PW-1:0]     presc_q, presc_d;
   logic [14:0]       us_cnt_q, us_cnt_d;
   logic              strobe_q;
   logic              arm_q;
   logic [7:0]        shadow_q [NUM_CH];
   logic [7:0]        shadow_d [NUM_CH];
   logic [7:0]        active_q [NUM_CH];
   logic [7:0]        active_d [NUM_CH];
   logic [14:0]       width    [NUM_CH];
   logic [NUM_CH-1:0] pwm_q, pwm_d;
   logic              frame_start_q, frame_start_d;
   logic              wr_ack_q, wr_ack_d;

   logic              tick;
   logic              wrap;
   logic [2:0]        wr_idx;
   logic              wr_ev;
   logic              wr_ok;

   always_comb begin
      tick   = (presc_q == PRESC_LAST);
      wrap   = tick && (us_cnt_q == FRAME_LAST);
      wr_idx = port_addr_i[2:0];
      // arm_q blocks a strobe that is already high when reset releases
      wr_ev  = port_addr_i[7] & ~strobe_q & arm_q;
      wr_ok  = wr_ev && ({1'b0, wr_idx} < NCH4);

      presc_d       = tick ? '0 : presc_q + PW'(1);
      us_cnt_d      = wrap ? '0 : (tick ? us_cnt_q + 15'd1 : us_cnt_q);
      frame_start_d = wrap;
      wr_ack_d      = wr_ok;

      pwm_d = '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
         shadow_d[ch] = (wr_ok && (wr_idx == 3'(ch))) ? port_data_i : shadow_q[ch];
         active_d[ch] = wrap ? shadow_q[ch] : active_q[ch];
         width[ch]    = MIN_W + 15'(active_q[ch]) * STEP_W;
         pwm_d[ch]    = (us_cnt_q < width[ch]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q       <= '0;
         us_cnt_q      <= '0;
         strobe_q      <= 1'b0;
         arm_q         <= 1'b0;
         pwm_q         <= '0;
         frame_start_q <= 1'b0;
         wr_ack_q      <= 1'b0;
         for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            shadow_q[ch] <= RST_POS;
            active_q[ch] <= RST_POS;
         end
      end else begin
         presc_q       <= presc_d;
         us_cnt_q      <= us_cnt_d;
         strobe_q      <= port_addr_i[7];
         arm_q         <= arm_q | ~port_addr_i[7];
         pwm_q         <= pwm_d;
         frame_start_q <= frame_start_d;
         wr_ack_q      <= wr_ack_d;
         for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            shadow_q[ch] <= shadow_d[ch];
            active_q[ch] <= active_d[ch];
         end
      end
   end

   assign pwm_o         = pwm_q;
   assign frame_start_o = frame_start_q;
   assign wr_ack_o      = wr_ack_q;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank with a shrunk timebase (2 clk/tick, 400-tick frame).
// Each frame is measured sample-by-sample on the falling edge and compared to hand-computed widths.
module tb_servo_pwm_bank;

   localparam int NCH = 5;

   logic           clk = 1'b0;
   logic           reset;
   logic [7:0]     port_addr_i;
   logic [7:0]     port_data_i;
   logic [NCH-1:0] pwm_o;
   logic           frame_start_o;
   logic           wr_ack_o;

   int errors = 0;
   int checks = 0;
   int hi_cnt [NCH];
   int period;
   int ack_cnt;

   always #5 clk = ~clk;

   servo_pwm_bank #(
      .NUM_CH   (NCH),
      .TICK_DIV (2),
      .FRAME_US (400),
      .MIN_US   (10),
      .STEP_US  (1),
      .RESET_POS(128)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .port_addr_i  (port_addr_i),
      .port_data_i  (port_data_i),
      .pwm_o        (pwm_o),
      .frame_start_o(frame_start_o),
      .wr_ack_o     (wr_ack_o)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Samples every falling edge until frame_start_o is seen (bounded), optionally
   // issuing up to two strobed writes at given sample indices (0 = unused).
   task automatic run_frame(input int w1, input logic [7:0] a1, input logic [7:0] d1,
                            input int w2, input logic [7:0] a2, input logic [7:0] d2,
                            input int hold);
      int  k = 0;
      bit  done = 0;
      ack_cnt = 0;
      for (int i = 0; i < NCH; i++) hi_cnt[i] = 0;
      while (!done && k < 2000) begin
         @(negedge clk);
         k++;
         if ((w1 > 0 && k == w1 + hold) || (w2 > 0 && k == w2 + hold)) port_addr_i = 8'h00;
         for (int i = 0; i < NCH; i++) if (pwm_o[i]) hi_cnt[i]++;
         if (wr_ack_o) ack_cnt++;
         if (frame_start_o) done = 1;
         else begin
            if (w1 > 0 && k == w1) begin port_addr_i = a1; port_data_i = d1; end
            if (w2 > 0 && k == w2) begin port_addr_i = a2; port_data_i = d2; end
         end
      end
      period = k;
   endtask

   task automatic expect_frame(input string tag, input int e0, input int e1, input int e2,
                               input int e3, input int e4, input int eack);
      int exp_hi [NCH];
      exp_hi = '{e0, e1, e2, e3, e4};
      check_eq($sformatf("%s period", tag), period, 800);
      for (int i = 0; i < NCH; i++)
         check_eq($sformatf("%s ch%0d", tag, i), hi_cnt[i], exp_hi[i]);
      check_eq($sformatf("%s wr_ack", tag), ack_cnt, eack);
   endtask

   initial begin
      reset       = 1'b1;
      port_addr_i = 8'h00;
      port_data_i = 8'h00;
      repeat (3) @(negedge clk);
      check_eq("rst pwm", int'(pwm_o), 0);
      check_eq("rst frame_start", int'(frame_start_o), 0);
      check_eq("rst wr_ack", int'(wr_ack_o), 0);
      reset = 1'b0;

      // frame 0 from reset release, default 128 -> 138 ticks -> 276 clocks
      run_frame(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
      expect_frame("f0", 276, 276, 276, 276, 276, 0);

      // ch2 <= 0 mid-frame, strobe held for 4 cycles: one ack, applies next frame
      run_frame(300, 8'h82, 8'h00, 0, 8'h00, 8'h00, 4);
      expect_frame("f1", 276, 276, 276, 276, 276, 1);
      run_frame(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
      expect_frame("f2", 276, 276, 20, 276, 276, 0);

      // two writes to ch0 in one frame: last (0x40 -> 74 ticks) wins
      run_frame(100, 8'h80, 8'hFF, 400, 8'h80, 8'h40, 1);
      expect_frame("f3", 276, 276, 20, 276, 276, 2);
      run_frame(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
      expect_frame("f4", 148, 276, 20, 276, 276, 0);

      // out-of-range index 7 is ignored
      run_frame(200, 8'h87, 8'h10, 0, 8'h00, 8'h00, 1);
      expect_frame("f5", 148, 276, 20, 276, 276, 0);
      run_frame(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
      expect_frame("f6", 148, 276, 20, 276, 276, 0);

      // write detected in the wrap cycle: active takes pre-write value
      run_frame(799, 8'h81, 8'h00, 0, 8'h00, 8'h00, 1);
      expect_frame("f7", 148, 276, 20, 276, 276, 1);
      run_frame(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
      expect_frame("f8", 148, 276, 20, 276, 276, 0);
      run_frame(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
      expect_frame("f9", 148, 20, 20, 276, 276, 0);

      // pending write to ch0, then reset in the middle of the ch0 pulse
      repeat (3) @(negedge clk);
      port_addr_i = 8'h80;
      port_data_i = 8'h00;
      @(negedge clk);
      port_addr_i = 8'h00;
      check_eq("pre-rst wr_ack", int'(wr_ack_o), 1);
      repeat (46) @(negedge clk);
      check_eq("pre-rst ch0 high", int'(pwm_o[0]), 1);
      #2;
      reset       = 1'b1;
      port_addr_i = 8'h80;
      #1;
      check_eq("async rst pwm", int'(pwm_o), 0);
      check_eq("async rst frame_start", int'(frame_start_o), 0);
      repeat (3) @(negedge clk);
      check_eq("held rst pwm", int'(pwm_o), 0);
      check_eq("held rst wr_ack", int'(wr_ack_o), 0);
      reset = 1'b0;

      // strobe held high through release must not write
      run_frame(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
      expect_frame("r0", 276, 276, 276, 276, 276, 0);
      port_addr_i = 8'h00;
      run_frame(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
      expect_frame("r1", 276, 276, 276, 276, 276, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/servo_pwm_bank.md
Name: servo_pwm_bank

Overview:
- Multi-channel RC-servo PWM generator for the robot palm. It sits directly downstream of the 8051 core's P1/P2 output ports.
- Firmware writes an 8-bit position to a channel using P1 as address/strobe and P2 as data. The block drives one 50 Hz servo pulse per finger channel.
- New positions are double-buffered and take effect only at frame boundaries, so no pulse is ever truncated or glitched.

Parameters:
- NUM_CH, 5, number of servo channels (1..8).
- TICK_DIV, 50, clk cycles per 1 us tick (50 MHz mcu_clk).
- FRAME_US, 20000, frame period in ticks (20 ms).
- MIN_US, 500, pulse width in ticks for position 0.
- STEP_US, 8, ticks added per position LSB; constraint MIN_US+255*STEP_US < FRAME_US.
- RESET_POS, 128, position loaded into all channels at reset.

Ports:
- clk  in  1  mcu clock, same domain as the 8051 core.
- reset  in  1  asynchronous, active-high reset.
- port_addr_i  in  8  from P1_o; bit7 = write strobe, bits[2:0] = channel index, bits[6:3] ignored.
- port_data_i  in  8  from P2_o; position value 0..255.
- pwm_o  out  NUM_CH  servo pulse outputs, registered.
- frame_start_o  out  1  one-cycle pulse at each frame wrap.
- wr_ack_o  out  1  one-cycle pulse when a position write is accepted.

Behaviour:
- Reset (async, active-high) values:
  - pwm_o=0, frame_start_o=0, wr_ack_o=0.
  - strobe_q=0, prescaler=0, us_cnt=0.
  - All shadow and active position registers = RESET_POS.
- Prescaler: counts 0..TICK_DIV-1. tick=1 in the cycle where prescaler==TICK_DIV-1, and the prescaler wraps to 0 on that cycle.
- us_cnt: increments on tick. On tick with us_cnt==FRAME_US-1 it wraps to 0. That same cycle is the frame wrap.
- Frame wrap cycle actions:
  - frame_start_o registers 1 on the following edge, giving a one-cycle pulse.
  - Every active[ch] <= shadow[ch].
- Write detection: strobe_q <= port_addr_i[7] every cycle. A write event occurs when port_addr_i[7]=1 and strobe_q=0, i.e. a rising edge. A level held high writes only once.
- Write event with idx=port_addr_i[2:0] < NUM_CH:
  - shadow[idx] <= port_data_i, sampled in the detection cycle.
  - wr_ack_o=1 on the next cycle.
- Write event with idx >= NUM_CH: ignored. No register changes and no wr_ack_o.
- Simultaneous write and frame wrap in the same cycle: the active copy uses the pre-write shadow value. The new value applies from the frame after next. Both frame_start_o and wr_ack_o pulse.
- Multiple writes to one channel within a frame: the last write wins at the next wrap.
- Width calculation:
  - width[ch] = MIN_US + active[ch]*STEP_US, unsigned.
  - us_cnt is 15 bits and width is 15 bits; no overflow is possible under the parameter constraint.
- Output: pwm_o[ch] <= (us_cnt < width[ch]), registered, so pwm_o lags us_cnt by one clock.
  - The pulse is high for exactly width[ch]*TICK_DIV clocks per frame.
  - Frame period is exactly FRAME_US*TICK_DIV clocks.
- First frame after reset release: pwm_o goes high on the first clock edge, using the RESET_POS width. The first frame_start_o pulse occurs at the end of frame 0.
- Reset asserted mid-frame or mid-pulse:
  - pwm_o drops to 0 immediately (async).
  - All pending shadow writes are discarded.
  - Counting restarts from 0 on release.
- A strobe already high at reset release does not produce a write; it needs a fresh 0->1 transition.

Test Plan:
Bench parameters: TICK_DIV=2, FRAME_US=400, MIN_US=10, STEP_US=1, NUM_CH=5, RESET_POS=128.
- Reset release, no writes -> every pwm_o high for 138*2=276 clocks per 800-clock frame. frame_start_o pulses every 800 clocks, first at clock ~800.
- Strobe rise with addr=0x82, data=0x00 mid-frame -> wr_ack_o pulses once. Ch2 stays at 276 clocks for the current frame, then 20 clocks from the next frame. Other channels unchanged.
- Write data=0xFF to ch0, then a second write data=0x40 to ch0 in the same frame -> next frame ch0 high 148 clocks (0x40=64, 74 ticks); 0xFF (530 clocks) is never observed.
- Strobe edge with addr=0x87 (idx 7 >= NUM_CH), data=0x10 -> no wr_ack_o; all widths unchanged over two frames.
- Strobe edge aligned to the frame-wrap cycle, addr=0x81, data=0x00 -> the following frame still has 276-clock ch1 pulses; the frame after has 20 clocks.
- Assert reset during a ch0 pulse after writing 0x00 -> pwm_o=0 immediately. After release ch0 returns to 276 clocks. Holding port_addr_i[7]=1 through release causes no write.
